// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        KILL_REQ,
        DRAIN
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, IR handoff
// to decode with PC stall and flush/redirect handling.
import ifetch_pkg::*;

module ifetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] pc,
    output logic        pc_stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:2] ir_pc,
    input  logic        id_ready,
    output logic [31:0] fetch_cnt
);

    state_t      state_q;
    state_t      state_d;
    logic [31:2] addr_q;
    logic        load_addr;
    logic        capture;
    logic        deliver;

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        imem_addr = addr_q;
        load_addr = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        pc_stall  = !(((state_q == HOLD) && id_ready) || flush);
        unique case (state_q)
            IDLE: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                load_addr = 1'b1;
                if (flush)
                    state_d = imem_gnt ? DRAIN : KILL_REQ;
                else
                    state_d = imem_gnt ? WAIT : REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt)
                    state_d = flush ? DRAIN : WAIT;
                else if (flush)
                    state_d = KILL_REQ;
            end
            WAIT: begin
                // Data arriving with a flush belongs to the old path
                if (imem_rvalid) begin
                    state_d = flush ? IDLE : HOLD;
                    capture = !flush;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (id_ready) begin
                    state_d = IDLE;
                    deliver = 1'b1;
                end
            end
            KILL_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (imem_rvalid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= RESET_PC[31:2];
            ir_valid  <= 1'b0;
            ir        <= NOP;
            ir_pc     <= RESET_PC[31:2];
            fetch_cnt <= 32'h0;
        end else begin
            state_q  <= state_d;
            ir_valid <= (state_d == HOLD);
            if (load_addr)
                addr_q <= pc;
            if (capture) begin
                ir    <= imem_rdata;
                ir_pc <= addr_q;
            end
            if (deliver)
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl.
`timescale 1ns/1ps

module tb_ifetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:2] pc;
    logic        pc_stall;
    logic        flush;
    logic        imem_req;
    logic [31:2] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:2] ir_pc;
    logic        id_ready;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    ifetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_stall   (pc_stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ir_valid   (ir_valid),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .id_ready   (id_ready),
        .fetch_cnt  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch from IDLE: grant, response, handoff; leaves FSM in IDLE
    task automatic deliver(input logic [31:2] a, input logic [31:0] d);
        pc = a;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = d;
        tick();
        imem_rvalid = 1'b0;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc = 30'hC00;
        flush = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        id_ready = 1'b0;
        #3;
        checks++;
        if (ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 30'hC00
            || fetch_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: vld=%b ir=%h ir_pc=%h cnt=%h exp 0/0/c00/0",
                     ir_valid, ir, ir_pc, fetch_cnt);
        end
        checks++;
        if (pc_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %b exp 1", pc_stall);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'hC00) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h exp 1/c00",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        pc = 30'hC00;
        imem_gnt = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'hC00 || pc_stall !== 1'b1) begin
            errors++;
            $display("FAIL zw_req: req=%b addr=%h stall=%b exp 1/c00/1",
                     imem_req, imem_addr, pc_stall);
        end
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h2408_0005;
        #1;
        checks++;
        if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL zw_wait: req=%b vld=%b exp 0/0", imem_req, ir_valid);
        end
        tick();
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        id_ready = 1'b1;
        #1;
        checks++;
        if (ir_valid !== 1'b1 || ir !== 32'h2408_0005 || ir_pc !== 30'hC00
            || pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL zw_hold: vld=%b ir=%h pc=%h stall=%b exp 1/24080005/c00/0",
                     ir_valid, ir, ir_pc, pc_stall);
        end
        tick();
        id_ready = 1'b0;
        pc = 30'hC01;
        #1;
        checks++;
        if (ir_valid !== 1'b0 || fetch_cnt !== 32'd1 || pc_stall !== 1'b1) begin
            errors++;
            $display("FAIL zw_done: vld=%b cnt=%0d stall=%b exp 0/1/1",
                     ir_valid, fetch_cnt, pc_stall);
        end
    endtask

    task automatic test_back_pressure();
        int bad;
        pc = 30'hC01;
        imem_gnt = 1'b0;
        tick();
        pc = 30'hC02;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            imem_gnt = (i == 2);
            #1;
            if (imem_req !== 1'b1 || imem_addr !== 30'hC01 || pc_stall !== 1'b1)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_req_stable: %0d bad cycles, exp addr c01 req 1 stall 1", bad);
        end
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h00A0_0093;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata = 32'h1234_5678;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ir_valid !== 1'b1 || ir !== 32'h00A0_0093 || ir_pc !== 30'hC01
                || pc_stall !== 1'b1)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold_stable: %0d bad cycles, exp ir 00a00093 pc c01", bad);
        end
        id_ready = 1'b1;
        #1;
        checks++;
        if (pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: stall=%b exp 0", pc_stall);
        end
        tick();
        id_ready = 1'b0;
        #1;
        checks++;
        if (fetch_cnt !== 32'd2 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: cnt=%0d vld=%b exp 2/0", fetch_cnt, ir_valid);
        end
    endtask

    task automatic test_flush_wait();
        int seen;
        pc = 30'hC03;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if (pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL fw_stall: stall=%b exp 0", pc_stall);
        end
        tick();
        flush = 1'b0;
        pc = 30'hC10;
        seen = 0;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        if (imem_req !== 1'b0) seen++;
        tick();
        imem_rvalid = 1'b0;
        #1;
        if (ir_valid !== 1'b0 || ir === 32'hDEAD_BEEF) seen++;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL fw_drop: %0d bad cycles, vld=%b ir=%h exp stale data dropped",
                     seen, ir_valid, ir);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'hC10) begin
            errors++;
            $display("FAIL fw_refetch: req=%b addr=%h exp 1/c10", imem_req, imem_addr);
        end
        deliver(30'hC10, 32'h0010_0113);
        checks++;
        if (ir_pc !== 30'hC10 || ir !== 32'h0010_0113 || fetch_cnt !== 32'd3) begin
            errors++;
            $display("FAIL fw_deliver: pc=%h ir=%h cnt=%0d exp c10/00100113/3",
                     ir_pc, ir, fetch_cnt);
        end
    endtask

    task automatic test_flush_req();
        int bad;
        pc = 30'hC11;
        imem_gnt = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pc = 30'hC20;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            imem_gnt = (i == 1);
            #1;
            if (imem_req !== 1'b1 || imem_addr !== 30'hC11) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fr_kill_req: %0d bad cycles, exp req 1 addr c11", bad);
        end
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1111_1111;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fr_drain_req: req=%b exp 0", imem_req);
        end
        tick();
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 30'hC20) begin
            errors++;
            $display("FAIL fr_refetch: vld=%b req=%b addr=%h exp 0/1/c20",
                     ir_valid, imem_req, imem_addr);
        end
        deliver(30'hC20, 32'h0020_0193);
        checks++;
        if (ir_pc !== 30'hC20 || fetch_cnt !== 32'd4) begin
            errors++;
            $display("FAIL fr_deliver: pc=%h cnt=%0d exp c20/4", ir_pc, fetch_cnt);
        end
    endtask

    task automatic test_flush_hold();
        pc = 30'hC21;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0030_0213;
        tick();
        imem_rvalid = 1'b0;
        flush = 1'b1;
        id_ready = 1'b1;
        #1;
        checks++;
        if (ir_valid !== 1'b1 || pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL fh_hold: vld=%b stall=%b exp 1/0", ir_valid, pc_stall);
        end
        tick();
        flush = 1'b0;
        id_ready = 1'b0;
        pc = 30'hC40;
        #1;
        checks++;
        if (ir_valid !== 1'b0 || fetch_cnt !== 32'd4 || imem_addr !== 30'hC40) begin
            errors++;
            $display("FAIL fh_nocount: vld=%b cnt=%0d addr=%h exp 0/4/c40",
                     ir_valid, fetch_cnt, imem_addr);
        end
    endtask

    task automatic test_wrap();
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        #1;
        checks++;
        if (fetch_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload: cnt=%h exp ffffffff", fetch_cnt);
        end
        deliver(30'hC40, 32'h0040_0293);
        checks++;
        if (fetch_cnt !== 32'h0) begin
            errors++;
            $display("FAIL wrap: cnt=%h exp 00000000", fetch_cnt);
        end
    endtask

    task automatic test_reset_mid();
        pc = 30'hC41;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b1;
        pc = 30'hC00;
        #1;
        checks++;
        if (ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 30'hC00
            || fetch_cnt !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 30'hC00
            || pc_stall !== 1'b1) begin
            errors++;
            $display("FAIL rm_reset: vld=%b ir=%h pc=%h cnt=%h req=%b addr=%h stall=%b",
                     ir_valid, ir, ir_pc, fetch_cnt, imem_req, imem_addr, pc_stall);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 30'hC00) begin
            errors++;
            $display("FAIL rm_req: req=%b addr=%h exp 1/c00", imem_req, imem_addr);
        end
        deliver(30'hC00, 32'h0050_0313);
        checks++;
        if (fetch_cnt !== 32'd1 || ir !== 32'h0050_0313 || ir_pc !== 30'hC00) begin
            errors++;
            $display("FAIL rm_deliver: cnt=%0d ir=%h pc=%h exp 1/00500313/c00",
                     fetch_cnt, ir, ir_pc);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_back_pressure();
        test_flush_wait();
        test_flush_req();
        test_flush_hold();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 The block SHALL have a clock input, clk, that is 1 bit wide; all state SHALL update on its rising edge.
REQ-002 The block SHALL have a reset input, rst, that is 1 bit wide, asynchronous and active-high.
REQ-003 pc  in  30 [31:2]  word address of the next instruction, from the PC register.
REQ-004 pc_stall  out  1  when high, the PC register SHALL NOT load (PCWr = !pc_stall).
REQ-005 flush  in  1  redirect: the fetch in progress SHALL be discarded, and pc carries the target from the next cycle onward.
REQ-006 imem_req  out  1; imem_addr  out  30 [31:2]; imem_gnt  in  1  request handshake to the instruction memory.
REQ-007 imem_rvalid  in  1; imem_rdata  in  32  response from the instruction memory, exactly one response per granted request.
REQ-008 ir_valid  out  1; ir  out  32; ir_pc  out  30 [31:2]; id_ready  in  1  instruction handoff to decode.
REQ-009 fetch_cnt  out  32  count of instructions delivered to decode.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, HOLD, KILL_REQ, DRAIN.
REQ-011 IDLE: imem_req=1 and imem_addr=pc (combinational); addr_q<=pc. On imem_gnt the FSM SHALL go to WAIT; otherwise it SHALL go to REQ.
REQ-012 REQ: imem_req=1 and imem_addr=addr_q, both held stable until imem_gnt; on imem_gnt the FSM SHALL go to WAIT.
REQ-013 Once raised, imem_req SHALL NOT drop before it is granted, flush included.
REQ-014 WAIT: imem_rvalid SHALL be sampled only in WAIT or DRAIN. On imem_rvalid the block SHALL set ir<=imem_rdata, ir_pc<=addr_q, ir_valid<=1 and go to HOLD.
REQ-015 HOLD: ir_valid=1, with ir and ir_pc stable. When id_ready=1: pc_stall=0 that cycle; next cycle ir_valid=0, fetch_cnt+=1, and the FSM goes to IDLE.
REQ-016 pc_stall SHALL be 1 in every cycle except (HOLD and id_ready) or flush.
REQ-017 Minimum latency: gnt in the IDLE cycle (T0), rvalid at T1, ir_valid high at T2. imem_rvalid SHALL NOT be accepted in the same cycle as its grant.
REQ-018 flush in IDLE with gnt, or in WAIT without rvalid, SHALL send the FSM to DRAIN.
REQ-019 flush in IDLE without gnt, or in REQ without gnt, SHALL send the FSM to KILL_REQ.
REQ-020 flush in HOLD SHALL give ir_valid=0 next cycle and send the FSM to IDLE; fetch_cnt SHALL NOT increment.
REQ-021 flush in WAIT coinciding with rvalid SHALL discard the data and send the FSM to IDLE.
REQ-022 KILL_REQ: imem_req=1 and imem_addr=addr_q until gnt, then the FSM SHALL go to DRAIN. DRAIN: the first imem_rvalid SHALL be dropped and the FSM SHALL go to IDLE.
REQ-023 flush in KILL_REQ or DRAIN SHALL be ignored, since the in-flight request is already discarded.
REQ-024 flush and id_ready together in HOLD: flush SHALL win; no delivery is made and there is no count.
REQ-025 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0 without saturating.
REQ-026 ir_valid SHALL be 0 in every state except HOLD.

Reset
REQ-027 On rst: state=IDLE, ir_valid=0, ir=32'h0000_0000, ir_pc=30'h0000_0C00 (byte address 0x3000), addr_q=30'h0000_0C00, fetch_cnt=0.
REQ-028 rst asserted mid-fetch SHALL abandon the outstanding request. The instruction memory shares rst, so no stale rvalid can follow.
REQ-029 In the first cycle after rst release, the block SHALL issue a request for the pc input.

Structure
REQ-030 A shared package ifetch_pkg SHALL hold the state enum, RESET_PC=32'h0000_3000 and NOP=32'h0000_0000.
REQ-031 The block SHALL be a single module with no sub-module; the FSM, the capture registers and the counter are inline.

Verification
REQ-032 Zero-wait fetch: pc=0xC00, gnt in the IDLE cycle, rvalid next cycle with 0x2408_0005, id_ready=1 -> ir=0x2408_0005 and ir_pc=0xC00 two cycles after the request, pc_stall low for 1 cycle, fetch_cnt=1.
REQ-033 Back-pressure: gnt delayed 3 cycles and id_ready low 4 cycles -> imem_addr stable through REQ, ir held stable, pc_stall high throughout, single delivery.
REQ-034 Flush in WAIT: flush with pc changing to 0xC10; stale rvalid 0xDEAD_BEEF arrives 2 cycles later -> dropped, never visible on ir; next request goes to 0xC10.
REQ-035 Flush in REQ: gnt withheld 2 more cycles -> imem_req stays high until gnt, one response is drained, then a fetch of the new pc.
REQ-036 Reset mid-WAIT: rst pulse -> all outputs at their REQ-027 values immediately; new request to 0xC00 after release.
REQ-037 Counter wrap: preload the count via 2^32-1 deliveries (or force fetch_cnt=32'hFFFF_FFFF) and deliver one more instruction -> fetch_cnt=0.
